// File: rtl/arb_pkg.sv
// Shared types and sizing helper for the weighted tenure arbiter.
// Types only; no latency or backpressure of its own.
package arb_pkg;

  typedef enum logic {IDLE = 1'b0, OWN = 1'b1} arb_state_e;

  // Index width with a floor of one bit so single-entry vectors still have a legal range.
  function automatic int idx_w(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Circular first-eligible search starting at pointer.
// Purely combinational, zero latency; no flow control.
module rr_pick
  import arb_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0]        eligible,
  input  logic [idx_w(WIDTH)-1:0] pointer,
  output logic                    found,
  output logic [idx_w(WIDTH)-1:0] index
);

  localparam int IW = idx_w(WIDTH);

  logic [IW-1:0] cand;

  // Walk from the farthest offset back to pointer so the nearest eligible entry wins.
  always_comb begin
    found = 1'b0;
    index = '0;
    cand  = '0;
    for (int k = WIDTH - 1; k >= 0; k--) begin
      cand = IW'((int'(pointer) + k) % WIDTH);
      if (eligible[cand]) begin
        found = 1'b1;
        index = cand;
      end
    end
  end

endmodule

// File: rtl/wrr_tenure_arb.sv
// Weighted round-robin arbiter; each grant is held until done, request drop or MAX_HOLD cycles.
// Grant one edge after request in IDLE, drops one edge after a release condition; owner holds via request.
module wrr_tenure_arb
  import arb_pkg::*;
#(
  parameter int WIDTH    = 4,
  parameter int WEIGHT_W = 4,
  parameter int MAX_HOLD = 16
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [WIDTH-1:0]            request,
  input  logic [WIDTH*WEIGHT_W-1:0]   weight,
  input  logic                        done,
  output logic [WIDTH-1:0]            grant,
  output logic                        grant_valid,
  output logic [idx_w(WIDTH)-1:0]     grant_id,
  output logic                        timeout
);

  localparam int IW = idx_w(WIDTH);
  localparam int HW = $clog2(MAX_HOLD + 1);

  arb_state_e          state;
  logic [IW-1:0]       pointer;
  logic [WEIGHT_W-1:0] credit     [WIDTH];
  logic [WEIGHT_W-1:0] eff_credit [WIDTH];
  logic [HW-1:0]       hold;
  logic [WIDTH-1:0]    has_credit;
  logic [WIDTH-1:0]    eligible;
  logic                reload;
  logic                pick_found;
  logic [IW-1:0]       pick_idx;
  logic                owner_req;
  logic                hold_max;
  logic                release_now;

  // Reload happens in the same cycle as the pick, so the pick sees the refreshed credits.
  always_comb begin
    has_credit = '0;
    eligible   = '0;
    for (int i = 0; i < WIDTH; i++) begin
      has_credit[i] = request[i] && (credit[i] != '0);
    end
    reload = (state == IDLE) && (request != '0) && (has_credit == '0);
    for (int i = 0; i < WIDTH; i++) begin
      eff_credit[i] = credit[i];
      if (reload) begin
        eff_credit[i] = (weight[i*WEIGHT_W +: WEIGHT_W] == '0) ? WEIGHT_W'(1)
                                                             : weight[i*WEIGHT_W +: WEIGHT_W];
      end
      eligible[i] = request[i] && (eff_credit[i] != '0);
    end
  end

  rr_pick #(.WIDTH(WIDTH)) u_pick (
    .eligible (eligible),
    .pointer  (pointer),
    .found    (pick_found),
    .index    (pick_idx)
  );

  // grant_id equals the owner for the whole of OWN.
  assign owner_req   = request[grant_id];
  assign hold_max    = (hold == HW'(MAX_HOLD));
  assign release_now = done || !owner_req || hold_max;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      pointer     <= '0;
      hold        <= '0;
      grant       <= '0;
      grant_valid <= 1'b0;
      grant_id    <= '0;
      timeout     <= 1'b0;
      for (int i = 0; i < WIDTH; i++) begin
        credit[i] <= '0;
      end
    end else begin
      timeout <= 1'b0;
      case (state)
        IDLE: begin
          if (pick_found) begin
            for (int i = 0; i < WIDTH; i++) begin
              credit[i] <= (IW'(i) == pick_idx && eff_credit[i] != '0) ? eff_credit[i] - 1'b1
                                                                       : eff_credit[i];
            end
            grant       <= WIDTH'(1) << pick_idx;
            grant_valid <= 1'b1;
            grant_id    <= pick_idx;
            pointer     <= (pick_idx == IW'(WIDTH - 1)) ? '0 : pick_idx + 1'b1;
            hold        <= HW'(1);
            state       <= OWN;
          end
        end
        OWN: begin
          if (release_now) begin
            grant       <= '0;
            grant_valid <= 1'b0;
            grant_id    <= '0;
            hold        <= '0;
            state       <= IDLE;
            timeout     <= hold_max && !done && owner_req;
          end else if (!hold_max) begin
            hold <= hold + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_wrr_tenure_arb.sv
// Directed bench for wrr_tenure_arb with hand-computed grant sequences.
module tb_wrr_tenure_arb;

  logic        clk     = 1'b0;
  logic        reset   = 1'b1;
  logic [3:0]  request = '0;
  logic [15:0] weight  = 16'h1111;
  logic        done    = 1'b0;
  logic [3:0]  grant;
  logic        grant_valid;
  logic [1:0]  grant_id;
  logic        timeout;
  logic [3:0]  req_q   = '0;

  int n_checks = 0;
  int n_err    = 0;
  int cnt0;

  logic [3:0] exp1    [9]  = '{4'b0001, 4'b0000, 4'b0010, 4'b0000, 4'b0100,
                                4'b0000, 4'b1000, 4'b0000, 4'b0001};
  logic [1:0] exp1_id [9]  = '{2'd0, 2'd0, 2'd1, 2'd0, 2'd2, 2'd0, 2'd3, 2'd0, 2'd0};
  logic [3:0] exp2    [16] = '{4'b0001, 4'b0000, 4'b0010, 4'b0000, 4'b0001, 4'b0000,
                                4'b0001, 4'b0000, 4'b0010, 4'b0000, 4'b0001, 4'b0000,
                                4'b0001, 4'b0000, 4'b0001, 4'b0000};
  logic [3:0] exp5    [8]  = '{4'b0010, 4'b0000, 4'b1000, 4'b0000,
                                4'b0010, 4'b0000, 4'b1000, 4'b0000};

  always #5 clk = ~clk;

  wrr_tenure_arb #(.WIDTH(4), .WEIGHT_W(4), .MAX_HOLD(16)) dut (
    .clk         (clk),
    .reset       (reset),
    .request     (request),
    .weight      (weight),
    .done        (done),
    .grant       (grant),
    .grant_valid (grant_valid),
    .grant_id    (grant_id),
    .timeout     (timeout)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset   = 1'b0;
    request = '0;
    done    = 1'b0;
    repeat (2) @(negedge clk);
    reset   = 1'b1;
  endtask

  // Request seen by the DUT at the last rising edge.
  always @(posedge clk) req_q <= request;

  always @(negedge clk) begin
    if (reset) begin
      check("onehot0", 32'($onehot0(grant)), 32'd1);
      check("subset", 32'(grant & ~req_q), 32'd0);
      check("gv_or", 32'(grant_valid), 32'(|grant));
    end
  end

  initial begin
    #1 reset = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_grant", 32'(grant), 32'd0);
    check("rst_gv", 32'(grant_valid), 32'd0);
    check("rst_id", 32'(grant_id), 32'd0);
    check("rst_to", 32'(timeout), 32'd0);

    // 1: equal weights, done every owned cycle
    reset   = 1'b1;
    weight  = 16'h1111;
    request = 4'b1111;
    done    = 1'b1;
    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      check("t1_grant", 32'(grant), 32'(exp1[i]));
      check("t1_id", 32'(grant_id), 32'(exp1_id[i]));
    end

    // 2: weight0=3, weight1=1
    do_reset();
    weight  = 16'h1113;
    request = 4'b0011;
    done    = 1'b1;
    cnt0    = 0;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      check("t2_grant", 32'(grant), 32'(exp2[i]));
      if (grant == 4'b0001) cnt0++;
    end
    check("t2_share0", 32'(cnt0), 32'd6);

    // 3: forced release after MAX_HOLD
    do_reset();
    weight  = 16'h1111;
    request = 4'b0001;
    done    = 1'b0;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      check("t3_hold", 32'(grant), 32'd1);
      check("t3_to_lo", 32'(timeout), 32'd0);
    end
    @(negedge clk);
    check("t3_rel", 32'(grant), 32'd0);
    check("t3_to", 32'(timeout), 32'd1);
    @(negedge clk);
    check("t3_regrant", 32'(grant), 32'd1);
    check("t3_to_end", 32'(timeout), 32'd0);

    // 4: owner drops request mid-tenure
    do_reset();
    weight  = 16'h1111;
    request = 4'b0101;
    done    = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("t4_own0", 32'(grant), 32'd1);
    end
    request = 4'b0100;
    @(negedge clk);
    check("t4_drop", 32'(grant), 32'd0);
    check("t4_to_drop", 32'(timeout), 32'd0);
    @(negedge clk);
    check("t4_next", 32'(grant), 32'b0100);
    check("t4_id", 32'(grant_id), 32'd2);
    check("t4_to_next", 32'(timeout), 32'd0);

    // 5: zero weights act as weight 1
    do_reset();
    weight  = 16'h0000;
    request = 4'b1010;
    done    = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      check("t5_grant", 32'(grant), 32'(exp5[i]));
    end

    // 6: asynchronous reset mid-tenure
    do_reset();
    weight  = 16'h1111;
    request = 4'b0100;
    done    = 1'b0;
    @(negedge clk);
    check("t6_own2", 32'(grant), 32'b0100);
    #2 reset = 1'b0;
    #1;
    check("t6_async", 32'(grant), 32'd0);
    check("t6_async_gv", 32'(grant_valid), 32'd0);
    check("t6_async_id", 32'(grant_id), 32'd0);
    request = 4'b1111;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("t6_restart", 32'(grant), 32'd1);
    check("t6_restart_id", 32'(grant_id), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", n_err);
    $fatal(1, "watchdog expired");
  end

endmodule
